// File: rtl/player_input.sv
// Merges HPS keyboard events and two joystick pads into per-player control words.
// It also produces a toggling pause latch.
// Optional macro PLAYER_INPUT_COIN_PULSE_EN: when defined, a coin edge produces a
// fixed-width pulse of COIN_PULSE_CYCLES instead of following the merged level.
module player_input #(
   parameter logic [23:0] COIN_PULSE_CYCLES = 24'd2000000
) (
   input  logic        clk_sys,
   input  logic        reset_sys_n,
   input  logic [10:0] ps2_key,
   input  logic [10:0] joystick_0,
   input  logic [10:0] joystick_1,
   output logic [9:0]  player1,
   output logic [9:0]  player2,
   output logic        pause
);
   localparam int B_COIN = 8;

   logic        tog_q;
   logic        armed_q;
   logic        key_evt;
   logic [9:0]  key1_q;
   logic [9:0]  key2_q;
   logic        key_pause_q;
   logic [9:0]  lvl1;
   logic [9:0]  lvl2;
   logic        pause_lvl;
   logic        pause_prev_q;
   logic [1:0]  coin_nxt;
   logic        unused_ps2_ext;

   // The extended-code flag carries no meaning for any mapped key.
   assign unused_ps2_ext = ps2_key[8];

   // Reorders a pad into the output packing {service, coin, start, b3, b2, b1, right, left, down, up}.
   function automatic logic [9:0] joy_pack(input logic [10:0] j);
      return {j[10], j[8], j[7], j[6], j[5], j[4], j[0], j[1], j[2], j[3]};
   endfunction

   assign key_evt   = armed_q && (ps2_key[10] != tog_q);
   assign lvl1      = key1_q | joy_pack(joystick_0);
   assign lvl2      = key2_q | joy_pack(joystick_1);
   assign pause_lvl = key_pause_q | joystick_0[9] | joystick_1[9];

   // Toggle history. armed_q suppresses a spurious event on the first cycle out of reset.
   always_ff @(posedge clk_sys or negedge reset_sys_n) begin
      if (!reset_sys_n) begin
         tog_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         tog_q   <= ps2_key[10];
         armed_q <= 1'b1;
      end
   end

   // Key registers loaded from the pressed flag of each recognised scan code.
   always_ff @(posedge clk_sys or negedge reset_sys_n) begin
      if (!reset_sys_n) begin
         key1_q      <= '0;
         key2_q      <= '0;
         key_pause_q <= 1'b0;
      end else if (key_evt) begin
         case (ps2_key[7:0])
            8'h75: key1_q[0]   <= ps2_key[9];
            8'h72: key1_q[1]   <= ps2_key[9];
            8'h6B: key1_q[2]   <= ps2_key[9];
            8'h74: key1_q[3]   <= ps2_key[9];
            8'h14: key1_q[4]   <= ps2_key[9];
            8'h11: key1_q[5]   <= ps2_key[9];
            8'h29: key1_q[6]   <= ps2_key[9];
            8'h16: key1_q[7]   <= ps2_key[9];
            8'h2E: key1_q[8]   <= ps2_key[9];
            8'h46: key1_q[9]   <= ps2_key[9];
            8'h4D: key_pause_q <= ps2_key[9];
            8'h2D: key2_q[0]   <= ps2_key[9];
            8'h2B: key2_q[1]   <= ps2_key[9];
            8'h23: key2_q[2]   <= ps2_key[9];
            8'h34: key2_q[3]   <= ps2_key[9];
            8'h1C: key2_q[4]   <= ps2_key[9];
            8'h1B: key2_q[5]   <= ps2_key[9];
            8'h15: key2_q[6]   <= ps2_key[9];
            8'h1E: key2_q[7]   <= ps2_key[9];
            8'h36: key2_q[8]   <= ps2_key[9];
            8'h45: key2_q[9]   <= ps2_key[9];
            default: ;
         endcase
      end
   end

`ifdef PLAYER_INPUT_COIN_PULSE_EN
   logic [1:0]  coin_lvl;
   logic [1:0]  coin_act;
   logic [1:0]  coin_prev_q;
   logic [23:0] coin_cnt_q [2];

   // The registered coin output bit itself is the pulse-active flag.
   assign coin_lvl = {lvl2[B_COIN], lvl1[B_COIN]};
   assign coin_act = {player2[B_COIN], player1[B_COIN]};

   // Next coin bit: keep high until the down-counter reaches terminal count, otherwise start on a rising edge.
   always_comb begin
      coin_nxt = '0;
      for (int i = 0; i < 2; i++) begin
         coin_nxt[i] = coin_act[i] ? (coin_cnt_q[i] != 24'd0)
                                   : (coin_lvl[i] && !coin_prev_q[i]);
      end
   end

   // Coin edge history and pulse-width down-counters. Edges during a pulse are ignored.
   always_ff @(posedge clk_sys or negedge reset_sys_n) begin
      if (!reset_sys_n) begin
         coin_prev_q <= '0;
         for (int i = 0; i < 2; i++) coin_cnt_q[i] <= '0;
      end else begin
         coin_prev_q <= coin_lvl;
         for (int i = 0; i < 2; i++) begin
            if (coin_act[i]) begin
               if (coin_cnt_q[i] != 24'd0) coin_cnt_q[i] <= coin_cnt_q[i] - 24'd1;
            end else if (coin_lvl[i] && !coin_prev_q[i]) begin
               coin_cnt_q[i] <= COIN_PULSE_CYCLES - 24'd1;
            end
         end
      end
   end
`else
   localparam logic [23:0] UNUSED_COIN_PULSE = COIN_PULSE_CYCLES;

   assign coin_nxt = {lvl2[B_COIN], lvl1[B_COIN]};
`endif

   // Output registers: one edge of latency from the merged levels.
   always_ff @(posedge clk_sys or negedge reset_sys_n) begin
      if (!reset_sys_n) begin
         player1 <= '0;
         player2 <= '0;
      end else begin
         player1 <= {lvl1[9], coin_nxt[0], lvl1[7:0]};
         player2 <= {lvl2[9], coin_nxt[1], lvl2[7:0]};
      end
   end

   // Pause latch toggles once per rising edge of the merged pause level.
   always_ff @(posedge clk_sys or negedge reset_sys_n) begin
      if (!reset_sys_n) begin
         pause_prev_q <= 1'b0;
         pause        <= 1'b0;
      end else begin
         pause_prev_q <= pause_lvl;
         if (pause_lvl && !pause_prev_q) pause <= ~pause;
      end
   end
endmodule
